byte_serializer: RTL

//  Parallel-in/serial-out stage directly downstream of the 8-bit bit-reversal stage; consumes its

---
 rtl/byte_serializer_if.sv | 23 ++
 rtl/byte_serializer.sv | 114 +++++++++++
 2 files changed

// File: rtl/byte_serializer_if.sv
// Handshake bundle between the parallel word source, the serializer and the serial sink.
// The serializer takes the slave view; the environment driving it takes the master view.
interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last
    );

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-in/serial-out stage: one word in, WIDTH bits out with valid/ready on both sides.
// A shift register plus one holding register lets words stream back to back with no gap.
//
//  state | meaning
//  IDLE  | shift register empty, nothing on the serial side
//  SHIFT | shift register holds bits of the current word, ser_valid high
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_serializer_if.slave      bus,
    output logic                  busy
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sr, sr_n;
    logic [WIDTH-1:0]  hr, hr_n;
    logic              hr_full, hr_full_n;
    logic [CW-1:0]     cnt, cnt_n;

    logic              in_acc;
    logic              out_acc;
    logic              last_acc;
    logic [WIDTH-1:0]  sr_shifted;

    // Handshake outputs come straight from registers, so neither ready nor valid
    // depends combinationally on the opposite side of its own handshake.
    assign bus.in_ready  = ~hr_full;
    assign bus.ser_valid = (state == SHIFT);
    assign bus.ser_out   = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign bus.ser_last  = (state == SHIFT) && (cnt == CNT_LAST);
    assign busy          = (state == SHIFT) | hr_full;

    assign in_acc     = bus.in_valid & ~hr_full;
    assign out_acc    = (state == SHIFT) & bus.ser_ready;
    assign last_acc   = out_acc & (cnt == CNT_LAST);
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            hr      <= '0;
            hr_full <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            hr      <= hr_n;
            hr_full <= hr_full_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        hr_n      = hr;
        hr_full_n = hr_full;
        cnt_n     = cnt;

        unique case (state)
            IDLE: begin
                if (in_acc) begin
                    sr_n    = bus.in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_acc) begin
                    if (hr_full) begin
                        sr_n      = hr;
                        hr_full_n = 1'b0;
                        cnt_n     = '0;
                    end else if (in_acc) begin
                        // Word arriving exactly as the last bit leaves skips the holding register.
                        sr_n  = bus.in_data;
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (out_acc) begin
                    sr_n  = sr_shifted;
                    cnt_n = cnt + 1'b1;
                end

                if (in_acc && !last_acc) begin
                    hr_n      = bus.in_data;
                    hr_full_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.ser_valid && !bus.ser_ready) |=>
            (bus.ser_valid && $stable(bus.ser_out) && $stable(bus.ser_last)));

    a_hr_only_in_shift: assert property (@(posedge clk) disable iff (rst)
        hr_full |-> (state == SHIFT));
endmodule
